alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_regfile.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field layout and controller FSM states.
package alu_pkg;

  localparam int DATA_W    = 4;
  localparam int INSTR_W   = 14;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  // Instruction field layout: [13] ldi, [12:10] op, [9:8] rd, [7:6] rs1, [5:4] rs2, [3:0] imm
  localparam int LDI_BIT = 13;
  localparam int OP_LSB  = 10;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, external-ALU and response signals of the issue controller.
// The controller uses the slave modport; the instruction source/ALU side uses master.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [OP_W-1:0]      alu_op;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_carry;
  logic                 alu_zero;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;
  logic                 res_carry;
  logic                 res_zero;
  logic [REG_IDX_W-1:0] res_rd;

  modport slave (
    input  instr_valid, instr, alu_result, alu_carry, alu_zero, res_ready,
    output instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_carry, res_zero, res_rd
  );

  modport master (
    output instr_valid, instr, alu_result, alu_carry, alu_zero, res_ready,
    input  instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_carry, res_zero, res_rd
  );

endinterface

// File: rtl/alu_regfile.sv
// 4 x 4-bit register file: one synchronous write port, two combinational read ports.
module alu_regfile
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset has priority so an in-flight write-back is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one instruction at a time, drives the external
// ALU for one cycle, writes back to the register file and holds the response.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_issue_ctrl_if.slave bus
);

  state_t               state;
  logic                 instr_ready_q;
  logic [OP_W-1:0]      op_p1;
  logic [REG_IDX_W-1:0] rd_p1;
  logic [DATA_W-1:0]    opa_p1;
  logic [DATA_W-1:0]    opb_p1;
  logic                 vld_p2;
  logic [DATA_W-1:0]    res_data_p2;
  logic                 res_carry_p2;
  logic                 res_zero_p2;
  logic [REG_IDX_W-1:0] res_rd_p2;

  logic                 f_ldi;
  logic [OP_W-1:0]      f_op;
  logic [REG_IDX_W-1:0] f_rd;
  logic [REG_IDX_W-1:0] f_rs1;
  logic [REG_IDX_W-1:0] f_rs2;
  logic [IMM_W-1:0]     f_imm;
  logic                 accept;
  logic                 in_exec;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rf_rdata1;
  logic [DATA_W-1:0]    rf_rdata2;

  assign f_ldi  = bus.instr[LDI_BIT];
  assign f_op   = bus.instr[OP_LSB  +: OP_W];
  assign f_rd   = bus.instr[RD_LSB  +: REG_IDX_W];
  assign f_rs1  = bus.instr[RS1_LSB +: REG_IDX_W];
  assign f_rs2  = bus.instr[RS2_LSB +: REG_IDX_W];
  assign f_imm  = bus.instr[IMM_LSB +: IMM_W];

  assign accept  = bus.instr_valid & instr_ready_q;
  assign in_exec = (state == ST_EXEC);

  // ldi writes on its accept edge; ALU results write at the end of EXEC.
  assign rf_we    = (accept & f_ldi) | in_exec;
  assign rf_waddr = in_exec ? rd_p1 : f_rd;
  assign rf_wdata = in_exec ? bus.alu_result : f_imm;

  alu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (f_rs1),
    .raddr2 (f_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      instr_ready_q <= 1'b1;
      op_p1         <= '0;
      rd_p1         <= '0;
      opa_p1        <= '0;
      opb_p1        <= '0;
      vld_p2        <= 1'b0;
      res_data_p2   <= '0;
      res_carry_p2  <= 1'b0;
      res_zero_p2   <= 1'b0;
      res_rd_p2     <= '0;
    end else begin
      case (state)
        // p1: capture decode and source operands as they stand before this edge
        ST_IDLE: begin
          if (accept) begin
            op_p1         <= f_op;
            rd_p1         <= f_rd;
            opa_p1        <= rf_rdata1;
            opb_p1        <= rf_rdata2;
            instr_ready_q <= 1'b0;
            if (f_ldi) begin
              vld_p2       <= 1'b1;
              res_data_p2  <= f_imm;
              res_carry_p2 <= 1'b0;
              res_zero_p2  <= (f_imm == '0);
              res_rd_p2    <= f_rd;
              state        <= ST_RESP;
            end else begin
              state        <= ST_EXEC;
            end
          end
        end
        // p2: capture the external ALU outputs untouched
        ST_EXEC: begin
          vld_p2       <= 1'b1;
          res_data_p2  <= bus.alu_result;
          res_carry_p2 <= bus.alu_carry;
          res_zero_p2  <= bus.alu_zero;
          res_rd_p2    <= rd_p1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            vld_p2        <= 1'b0;
            instr_ready_q <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state         <= ST_IDLE;
          instr_ready_q <= 1'b1;
          vld_p2        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.alu_a       = in_exec ? opa_p1 : '0;
  assign bus.alu_b       = in_exec ? opb_p1 : '0;
  assign bus.alu_op      = in_exec ? op_p1  : '0;
  assign bus.res_valid   = vld_p2;
  assign bus.res_data    = res_data_p2;
  assign bus.res_carry   = res_carry_p2;
  assign bus.res_zero    = res_zero_p2;
  assign bus.res_rd      = res_rd_p2;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   err_cnt;
  int   chk_cnt;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: carry is carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (bus.alu_op)
      OP_ADD: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_AND: t = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:  t = {1'b0, bus.alu_a | bus.alu_b};
      OP_XOR: t = {1'b0, bus.alu_a ^ bus.alu_b};
      OP_NOT: t = {1'b0, ~bus.alu_a};
      OP_SHL: t = {bus.alu_a[3], bus.alu_a[2:0], 1'b0};
      OP_SHR: t = {bus.alu_a[0], 1'b0, bus.alu_a[3:1]};
      default: t = 5'd0;
    endcase
    bus.alu_result = t[3:0];
    bus.alu_carry  = t[4];
    bus.alu_zero   = (t[3:0] == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, 2'b00, 2'b00, imm};
  endfunction

  function automatic logic [13:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, op, rd, rs1, rs2, 4'b0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction, checks ALU drive (ALU ops), latency and the response, then completes the handshake.
  task automatic do_instr(input string tag, input logic [13:0] ins,
                          input logic [3:0] ea, input logic [3:0] eb,
                          input logic [3:0] ed, input logic ec, input logic ez,
                          input logic [1:0] erd);
    logic [2:0] eop;
    eop = ins[12:10];
    chk({tag, " ready"}, bus.instr_ready, 1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    if (!ins[13]) begin
      chk({tag, " early_valid"}, bus.res_valid, 0);
      chk({tag, " alu_a"}, bus.alu_a, ea);
      chk({tag, " alu_b"}, bus.alu_b, eb);
      chk({tag, " alu_op"}, bus.alu_op, eop);
      tick();
    end
    chk({tag, " res_valid"}, bus.res_valid, 1);
    chk({tag, " res_data"}, bus.res_data, ed);
    chk({tag, " res_carry"}, bus.res_carry, ec);
    chk({tag, " res_zero"}, bus.res_zero, ez);
    chk({tag, " res_rd"}, bus.res_rd, erd);
    chk({tag, " busy"}, bus.instr_ready, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, " drained"}, bus.res_valid, 0);
  endtask

  // Reads Rn through the ALU path with OR Rn <- Rn | Rn (value unchanged).
  task automatic rd_reg(input string tag, input logic [1:0] n, input logic [3:0] v);
    do_instr(tag, mk_alu(OP_OR, n, n, n), v, v, v, 1'b0, (v == 4'd0), n);
  endtask

  initial begin
    int n_acc;
    int last;
    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.res_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst instr_ready", bus.instr_ready, 1);
    chk("rst res_valid", bus.res_valid, 0);
    chk("rst alu_a", bus.alu_a, 0);
    chk("rst alu_b", bus.alu_b, 0);
    chk("rst alu_op", bus.alu_op, 0);

    // 9 + 8 = 17 -> 1 with carry
    do_instr("ldi r1", mk_ldi(2'd1, 4'd9), 0, 0, 4'd9, 0, 0, 2'd1);
    do_instr("ldi r2", mk_ldi(2'd2, 4'd8), 0, 0, 4'd8, 0, 0, 2'd2);
    do_instr("add r3", mk_alu(OP_ADD, 2'd3, 2'd1, 2'd2), 4'd9, 4'd8, 4'd1, 1, 0, 2'd3);
    rd_reg("read r3", 2'd3, 4'd1);

    // 3 - 5 = 0xE with borrow; 3 - 3 = 0
    do_instr("ldi r1b", mk_ldi(2'd1, 4'd3), 0, 0, 4'd3, 0, 0, 2'd1);
    do_instr("ldi r2b", mk_ldi(2'd2, 4'd5), 0, 0, 4'd5, 0, 0, 2'd2);
    do_instr("sub r0", mk_alu(OP_SUB, 2'd0, 2'd1, 2'd2), 4'd3, 4'd5, 4'hE, 1, 0, 2'd0);
    do_instr("sub self", mk_alu(OP_SUB, 2'd0, 2'd1, 2'd1), 4'd3, 4'd3, 4'd0, 0, 1, 2'd0);

    // Back-pressure: 3 + 5 = 8 held for 5 cycles while an ldi is offered
    chk("bp ready", bus.instr_ready, 1);
    bus.instr       = mk_alu(OP_ADD, 2'd0, 2'd1, 2'd2);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr       = mk_ldi(2'd3, 4'hF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp res_valid", bus.res_valid, 1);
      chk("bp res_data", bus.res_data, 4'd8);
      chk("bp res_rd", bus.res_rd, 2'd0);
      chk("bp res_carry", bus.res_carry, 0);
      chk("bp instr_ready", bus.instr_ready, 0);
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("bp idle ready", bus.instr_ready, 1);
    chk("bp idle valid", bus.res_valid, 0);
    rd_reg("bp r3 kept", 2'd3, 4'd1);

    // XOR of a register with itself into itself, then consumers see the new 0
    do_instr("ldi r2c", mk_ldi(2'd2, 4'hA), 0, 0, 4'hA, 0, 0, 2'd2);
    do_instr("xor r2", mk_alu(OP_XOR, 2'd2, 2'd2, 2'd2), 4'hA, 4'hA, 4'd0, 0, 1, 2'd2);
    do_instr("shl r1", mk_alu(OP_SHL, 2'd1, 2'd2, 2'd2), 4'd0, 4'd0, 4'd0, 0, 1, 2'd1);
    do_instr("not r0", mk_alu(OP_NOT, 2'd0, 2'd1, 2'd3), 4'd0, 4'd1, 4'hF, 0, 0, 2'd0);

    // Reset while in EXEC: R0=F, R3=1 before
    bus.instr       = mk_alu(OP_ADD, 2'd2, 2'd0, 2'd3);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("exec alu_a", bus.alu_a, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst exec ready", bus.instr_ready, 1);
    chk("rst exec valid", bus.res_valid, 0);
    chk("rst exec alu_a", bus.alu_a, 0);
    rd_reg("rst r0", 2'd0, 4'd0);
    rd_reg("rst r1", 2'd1, 4'd0);
    rd_reg("rst r2", 2'd2, 4'd0);
    rd_reg("rst r3", 2'd3, 4'd0);

    // Reset while in RESP
    bus.instr       = mk_ldi(2'd1, 4'd6);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("resp valid", bus.res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst resp ready", bus.instr_ready, 1);
    chk("rst resp valid", bus.res_valid, 0);
    rd_reg("rst resp r1", 2'd1, 4'd0);

    // Throughput: continuous offers with the consumer always ready
    bus.res_ready   = 1'b1;
    bus.instr       = mk_alu(OP_OR, 2'd0, 2'd0, 2'd0);
    bus.instr_valid = 1'b1;
    n_acc = 0;
    last  = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_ready) begin
        if (last >= 0) chk("alu gap", i - last, 3);
        last = i;
        n_acc++;
      end
      tick();
    end
    chk("alu accepts", n_acc, 4);
    bus.instr = mk_ldi(2'd1, 4'd2);
    n_acc = 0;
    last  = -1;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_ready) begin
        if (last >= 0) chk("ldi gap", i - last, 2);
        last = i;
        n_acc++;
      end
      tick();
    end
    chk("ldi accepts", n_acc, 4);
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b0;
    tick();
    rd_reg("tput r1", 2'd1, 4'd2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
